// File: rtl/game_ctrl.sv
// Match sequencer for the Pong display pipeline: owns the round reset and
// animate enables for the bars and ball, detects missed balls from the ball
// edge coordinates, keeps both scores and paces serve/point pauses in frames.
module game_ctrl #(
  parameter int unsigned D_WIDTH      = 639,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_ani_stb,
  input  logic        in_start,
  input  logic [11:0] in_ball_x1,
  input  logic [11:0] in_ball_x2,
  output logic        out_round_reset,
  output logic        out_animate,
  output logic [3:0]  out_score_l,
  output logic [3:0]  out_score_r,
  output logic [2:0]  out_state,
  output logic [1:0]  out_winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [11:0] RIGHT_EDGE = 12'(D_WIDTH);

  state_t      state_q, state_d;
  logic [7:0]  frameCnt_q, frameCnt_d;
  logic [3:0]  scoreL_q, scoreL_d;
  logic [3:0]  scoreR_q, scoreR_d;
  logic [1:0]  winner_q, winner_d;
  logic        start_q;

  logic        startRise;
  logic        leftMiss;
  logic        rightMiss;

  // A left edge at zero or with bit 11 set means the ball left the screen on
  // the left (the centre-minus-size subtraction wrapped below zero); a right
  // edge with bit 11 set is such a wrapped value, never a right-hand miss.
  always_comb begin
    startRise = in_start & ~start_q;
    leftMiss  = (in_ball_x1 == 12'd0) | in_ball_x1[11];
    rightMiss = (in_ball_x2 >= RIGHT_EDGE) & ~in_ball_x2[11];
  end

  // Next-state, frame counter, score and winner logic for the match sequence.
  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    scoreL_d   = scoreL_q;
    scoreR_d   = scoreR_q;
    winner_d   = winner_q;
    case (state_q)
      IDLE: begin
        if (startRise) begin
          state_d    = SERVE;
          frameCnt_d = 8'd0;
          scoreL_d   = 4'd0;
          scoreR_d   = 4'd0;
          winner_d   = 2'd0;
        end
      end
      SERVE: begin
        if (in_ani_stb) begin
          if (frameCnt_q == SERVE_LAST) begin
            state_d    = PLAY;
            frameCnt_d = 8'd0;
          end else begin
            frameCnt_d = frameCnt_q + 8'd1;
          end
        end
      end
      PLAY: begin
        if (in_ani_stb) begin
          if (leftMiss) begin
            scoreR_d   = scoreR_q + 4'd1;
            state_d    = POINT;
            frameCnt_d = 8'd0;
          end else if (rightMiss) begin
            scoreL_d   = scoreL_q + 4'd1;
            state_d    = POINT;
            frameCnt_d = 8'd0;
          end
        end
      end
      POINT: begin
        if (in_ani_stb) begin
          if (frameCnt_q == POINT_LAST) begin
            frameCnt_d = 8'd0;
            if (scoreL_q == WIN) begin
              state_d  = OVER;
              winner_d = 2'd1;
            end else if (scoreR_q == WIN) begin
              state_d  = OVER;
              winner_d = 2'd2;
            end else begin
              state_d  = SERVE;
            end
          end else begin
            frameCnt_d = frameCnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (startRise) begin
          state_d    = IDLE;
          winner_d   = 2'd0;
          frameCnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        frameCnt_d = 8'd0;
      end
    endcase
  end

  // State registers; start_q comes out of reset high so a held button cannot
  // start a match the moment reset releases.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q    <= IDLE;
      frameCnt_q <= 8'd0;
      scoreL_q   <= 4'd0;
      scoreR_q   <= 4'd0;
      winner_q   <= 2'd0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      scoreL_q   <= scoreL_d;
      scoreR_q   <= scoreR_d;
      winner_q   <= winner_d;
      start_q    <= in_start;
    end
  end

  // Outputs decode straight from the registers so they change on the same
  // edge as the state.
  always_comb begin
    out_round_reset = (state_q == IDLE) || (state_q == SERVE);
    out_animate     = (state_q == PLAY);
    out_state       = state_q;
    out_score_l     = scoreL_q;
    out_score_r     = scoreR_q;
    out_winner      = winner_q;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Match sequencer for the Pong display pipeline.
- Drives the round reset and animate enables shared by both bar instances and the ball.
- Watches ball edge coordinates to detect missed balls and keeps both players' scores.
- Runs the match as idle -> serve -> play -> point -> game over, with frame-counted delays paced by the animation strobe.

Parameters:
D_WIDTH, 639, rightmost pixel column; the ball counts as missed on the right when its right edge reaches this column
WIN_SCORE, 5, score that ends the match (1-15)
SERVE_FRAMES, 60, animation strobes spent in SERVE before play starts (1-255)
POINT_FRAMES, 90, animation strobes spent in POINT after a miss (1-255)

Ports:
in_clock  in  1  base clock
in_reset  in  1  reset, synchronous, active-high
in_ani_stb  in  1  animation strobe, one in_clock cycle per frame
in_start  in  1  start button, level; only its rising edge is used
in_ball_x1  in  12  ball left edge
in_ball_x2  in  12  ball right edge
out_round_reset  out  1  drives the in_reset inputs of the bars and ball
out_animate  out  1  drives the in_animate inputs of the bars and ball
out_score_l  out  4  left player score
out_score_r  out  4  right player score
out_state  out  3  current state encoding, for the display and score overlay
out_winner  out  2  0 = none, 1 = left, 2 = right

Behaviour:
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Other codes are unused and recover to IDLE on the next clock.
- Outputs are decoded directly from registers, with no extra pipeline stage:
  - out_round_reset = (state==IDLE || state==SERVE)
  - out_animate = (state==PLAY)
  - out_state = state
- Reset, applied synchronously while in_reset is high:
  - state=IDLE, both scores=0, winner=0, frame counter=0.
  - The start-edge register start_q is set to 1, so a button still held when reset releases does not start a match.
  - Reset overrides every transition in the same cycle, including mid-match.
- Start edge: start_rise = in_start & ~start_q, with start_q <= in_start every cycle.
- IDLE:
  - On start_rise, go to SERVE; clear both scores, winner and frame counter.
- SERVE:
  - The counter increments on each in_ani_stb.
  - On the strobe where counter == SERVE_FRAMES-1, go to PLAY and clear the counter.
- PLAY: miss detection is evaluated only on cycles where in_ani_stb is high.
  - Left miss: in_ball_x1 == 0, or in_ball_x1[11] == 1 (the centre-minus-size subtraction wrapped).
  - Right miss: in_ball_x2 >= D_WIDTH and in_ball_x2[11] == 0.
  - Left miss: out_score_r increments and the state goes to POINT.
  - Right miss: out_score_l increments and the state goes to POINT.
  - Both misses on the same strobe: only the left miss counts (out_score_r increments).
  - No miss: stay in PLAY.
  - start_rise is ignored in PLAY.
- POINT:
  - The counter increments on each in_ani_stb. out_animate=0, so bars and ball freeze in place.
  - On the strobe where counter == POINT_FRAMES-1, clear the counter.
  - If out_score_l == WIN_SCORE: go to OVER with winner=1.
  - Else if out_score_r == WIN_SCORE: go to OVER with winner=2.
  - Otherwise go to SERVE.
- OVER:
  - Scores and winner are held; outputs are frozen.
  - On start_rise, go to IDLE and set winner=0. Scores hold until the next IDLE->SERVE transition.
- Scores are 4-bit and increment by exactly one per miss. They cannot exceed WIN_SCORE, because OVER is entered before any further play.
- start_rise is ignored in SERVE, PLAY and POINT.
- in_ani_stb is ignored in IDLE and OVER.
- The frame counter is 8-bit and is cleared on every state transition.

Test Plan:
- Reset then start: hold in_start=1 through reset release -> stays IDLE. Release and press again -> SERVE next cycle, out_round_reset=1, out_animate=0.
- Serve timing: SERVE_FRAMES=3, strobe every 4 clocks -> PLAY entered on the clock after the 3rd strobe. out_animate=1 and out_round_reset=0 in that cycle.
- Left miss with wrap: in PLAY, in_ball_x1=12'hFFE on a strobe -> out_score_r 0->1, state=POINT, out_animate=0. The same value with in_ani_stb=0 -> no change.
- Simultaneous misses: in_ball_x1=0 and in_ball_x2=639 on one strobe -> only out_score_r increments. Right miss alone at in_ball_x2=640 -> out_score_l increments.
- Match end: WIN_SCORE=2, two right misses -> after POINT_FRAMES strobes, state=OVER, out_winner=1, out_score_l=2. start_rise -> IDLE, winner=0. Next start_rise -> SERVE, scores=0.
- Reset mid-PLAY: assert in_reset for one clock -> next cycle state=IDLE, scores=0, out_round_reset=1.
